flash_op_scheduler: RTL and testbench
=====================================

FLASH_OP_SCHEDULER -- requirements
Module: flash_op_scheduler

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 4096, the maximum RUN-state cycles per operation when the timeout feature is compiled in.
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, the number of consecutive lost arbitrations after which a pending read wins.
REQ-003 SHALL provide `clk`, input, 1 bit: the single clock; all logic samples on its rising edge.
REQ-004 SHALL provide `rst`, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL provide `req_read`, `req_write` and `req_erase`, each an input of 1 bit: level requests, held by the requester until it receives its grant.
REQ-006 SHALL provide `read_busy`, `write_busy` and `erase_busy`, each an input of 1 bit: high while the corresponding engine is not in its idle state.
REQ-007 SHALL provide `en_read`, `en_write` and `en_erase`, each an output of 1 bit: a one-cycle start pulse to the corresponding engine.
REQ-008 SHALL provide `gnt`, output, 3 bits, one-hot ({erase, write, read}): a one-cycle acknowledge to the winning requester.
REQ-009 SHALL provide `op_active`, output, 2 bits: the current operation (0 none, 1 read, 2 write, 3 erase).
REQ-010 SHALL provide `sched_state`, output, 3 bits: the FSM state encoding.
REQ-011 SHALL provide `timeout_err`, output, 1 bit: a sticky flag indicating that an engine hung or never started.

Function
REQ-012 SHALL implement the states IDLE=0, ARB=1, ISSUE=2, WAIT_BUSY=3, RUN=4, DONE=5, ERR=6; any other encoding SHALL go to IDLE on the next cycle.
REQ-013 IDLE SHALL go to ARB when any request is high, and otherwise remain in IDLE.
REQ-014 ARB SHALL pick exactly one winner, latch it into op_active, and go to ISSUE:
- Default priority is erase > write > read.
- If req_read is high and starve_cnt >= STARVE_LIMIT, read wins regardless of priority.
REQ-015 starve_cnt SHALL:
- increment, saturating at 7, in ARB when req_read is high and read loses;
- clear when read wins;
- otherwise hold its value.
REQ-016 ISSUE SHALL assert the matching en_* signal and the matching gnt bit for exactly one cycle, then go to WAIT_BUSY.
REQ-017 WAIT_BUSY SHALL behave as follows:
- Go to RUN on the first cycle the selected busy input is high.
- If that busy input is not high within 4 cycles of entry, go to ERR.
REQ-018 RUN SHALL go to DONE on the first cycle the selected busy input is low.
REQ-019 DONE SHALL clear op_active to 0 and go to IDLE; this gives a minimum of one idle cycle between operations.
REQ-020 ERR SHALL set timeout_err to 1, clear op_active to 0, and go to IDLE; timeout_err SHALL remain set until reset.
REQ-021 Busy inputs of engines that are not selected SHALL be ignored in every state.
REQ-022 Requests that arrive or drop while the FSM is outside ARB SHALL have no effect until the next ARB.
- A request dropped before ARB is never granted.
REQ-023 Latency from the first request high in IDLE to the en_* pulse SHALL be 2 cycles (IDLE→ARB, ARB→ISSUE, pulse during ISSUE).
REQ-024 At most one en_* output and at most one gnt bit SHALL be high in any cycle.

Reset
REQ-025 When rst is low at a clock edge, the block SHALL:
- go to IDLE;
- set en_*, gnt, op_active, starve_cnt, timeout_err and all internal counters to 0.
REQ-026 Reset asserted mid-operation SHALL abort scheduling immediately:
- No en_* is reissued.
- The engine's in-flight operation is not tracked afterwards.

Configuration
REQ-027 Macro FLASH_OP_TIMEOUT_EN SHALL control the RUN-state timeout.
- Defined: a RUN-state counter clears on RUN entry; if it reaches TIMEOUT_CYCLES-1 with busy still high, the FSM goes to ERR.
- Undefined: RUN waits indefinitely and no RUN counter exists.
- In both builds, the WAIT_BUSY 4-cycle check remains and timeout_err SHALL be driven.

Verification
REQ-028 Bench SHALL cover the following directed scenarios:
- Single read: req_read=1 from IDLE → en_read pulses 2 cycles later, gnt=3'b001, op_active=1; read_busy high 10 cycles then low → DONE then IDLE, op_active=0.
- Priority: req_read, req_write and req_erase all high together → erase granted first (gnt=3'b100), then write, then read, each after the previous busy falls.
- Starvation: req_read held high while req_write is re-asserted after each grant → read wins on the 5th ARB (starve_cnt=4), and starve_cnt returns to 0.
- No start: write granted, write_busy never rises → ERR entered 4 cycles after WAIT_BUSY entry, and timeout_err=1 until rst=0.
- Hang (FLASH_OP_TIMEOUT_EN defined, TIMEOUT_CYCLES=16): erase_busy stuck high → ERR after 16 RUN cycles; with the macro undefined, the FSM stays in RUN.
- Reset mid-RUN: rst=0 for one cycle during a read → next cycle IDLE, all outputs 0, and no en_* pulse is reissued.

Source files
------------

// File: rtl/flash_op_scheduler.sv
// Flash operation scheduler: arbitrates read/write/erase requests and sequences one engine at a time.
// Optional RUN-state hang timeout is compiled in with `define FLASH_OP_TIMEOUT_EN.
module flash_op_scheduler #(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned STARVE_LIMIT   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_read,
  input  logic       req_write,
  input  logic       req_erase,
  input  logic       read_busy,
  input  logic       write_busy,
  input  logic       erase_busy,
  output logic       en_read,
  output logic       en_write,
  output logic       en_erase,
  output logic [2:0] gnt,
  output logic [1:0] op_active,
  output logic [2:0] sched_state,
  output logic       timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ARB       = 3'd1,
    S_ISSUE     = 3'd2,
    S_WAIT_BUSY = 3'd3,
    S_RUN       = 3'd4,
    S_DONE      = 3'd5,
    S_ERR       = 3'd6
  } state_t;

  localparam logic [1:0] OP_NONE  = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;
  localparam logic [1:0] OP_ERASE = 2'd3;

  // A RUN timeout of fewer than two cycles cannot be represented.
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("flash_op_scheduler: TIMEOUT_CYCLES must be at least 2");
  end

  state_t     state;
  logic [2:0] starve_cnt;
  logic [1:0] wait_cnt;
  logic       sel_busy;
  logic       starved;
  logic [1:0] winner;

`ifdef FLASH_OP_TIMEOUT_EN
  localparam int unsigned RUN_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [RUN_W-1:0] run_cnt;
`endif

  assign sched_state = state;

  // Only the busy line of the engine currently owning the scheduler matters.
  always_comb begin
    sel_busy = 1'b0;
    case (op_active)
      OP_READ:  sel_busy = read_busy;
      OP_WRITE: sel_busy = write_busy;
      OP_ERASE: sel_busy = erase_busy;
      default:  sel_busy = 1'b0;
    endcase
  end

  // Fixed priority erase > write > read, overridden by a starved read.
  always_comb begin
    starved = req_read && (32'(starve_cnt) >= STARVE_LIMIT);
    winner  = OP_NONE;
    if (starved)        winner = OP_READ;
    else if (req_erase) winner = OP_ERASE;
    else if (req_write) winner = OP_WRITE;
    else if (req_read)  winner = OP_READ;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      en_read     <= 1'b0;
      en_write    <= 1'b0;
      en_erase    <= 1'b0;
      gnt         <= 3'b000;
      op_active   <= OP_NONE;
      starve_cnt  <= 3'd0;
      wait_cnt    <= 2'd0;
      timeout_err <= 1'b0;
`ifdef FLASH_OP_TIMEOUT_EN
      run_cnt     <= '0;
`endif
    end else begin
      en_read  <= 1'b0;
      en_write <= 1'b0;
      en_erase <= 1'b0;
      gnt      <= 3'b000;
      case (state)
        S_IDLE: begin
          if (req_read || req_write || req_erase) state <= S_ARB;
        end
        S_ARB: begin
          op_active <= winner;
          wait_cnt  <= 2'd0;
          // Strobes are registered here so they are high during ISSUE.
          case (winner)
            OP_READ:  begin en_read  <= 1'b1; gnt <= 3'b001; end
            OP_WRITE: begin en_write <= 1'b1; gnt <= 3'b010; end
            OP_ERASE: begin en_erase <= 1'b1; gnt <= 3'b100; end
            default:  ;
          endcase
          state <= (winner == OP_NONE) ? S_IDLE : S_ISSUE;
          if (winner == OP_READ)
            starve_cnt <= 3'd0;
          else if (req_read && (starve_cnt != 3'd7))
            starve_cnt <= starve_cnt + 3'd1;
        end
        S_ISSUE: begin
          state <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (sel_busy) begin
            state <= S_RUN;
`ifdef FLASH_OP_TIMEOUT_EN
            run_cnt <= '0;
`endif
          end else if (wait_cnt == 2'd3) begin
            state <= S_ERR;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        S_RUN: begin
          if (!sel_busy) begin
            state <= S_DONE;
`ifdef FLASH_OP_TIMEOUT_EN
          end else if (run_cnt == RUN_W'(TIMEOUT_CYCLES - 1)) begin
            state <= S_ERR;
          end else begin
            run_cnt <= run_cnt + RUN_W'(1);
`endif
          end
        end
        S_DONE: begin
          op_active <= OP_NONE;
          state     <= S_IDLE;
        end
        S_ERR: begin
          timeout_err <= 1'b1;
          op_active   <= OP_NONE;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_op_scheduler.sv
// Directed bench for flash_op_scheduler: latency, priority, starvation, start timeout, hang, reset abort.
module tb_flash_op_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_read, req_write, req_erase;
  logic       read_busy, write_busy, erase_busy;
  logic       en_read, en_write, en_erase;
  logic [2:0] gnt;
  logic [1:0] op_active;
  logic [2:0] sched_state;
  logic       timeout_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  flash_op_scheduler #(.TIMEOUT_CYCLES(16), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .req_read(req_read), .req_write(req_write), .req_erase(req_erase),
    .read_busy(read_busy), .write_busy(write_busy), .erase_busy(erase_busy),
    .en_read(en_read), .en_write(en_write), .en_erase(en_erase),
    .gnt(gnt), .op_active(op_active), .sched_state(sched_state),
    .timeout_err(timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [2:0] exp);
    chk(tag, 32'(sched_state), 32'(exp));
  endtask

  // Starts in IDLE with the winning request pending; ends back in IDLE.
  task automatic grant_and_run(input string tag, input logic [2:0] g, input logic [1:0] op);
    tick();
    chk_state({tag, "_arb"}, 3'd1);
    tick();
    chk_state({tag, "_issue"}, 3'd2);
    chk({tag, "_gnt"}, 32'(gnt), 32'(g));
    chk({tag, "_en"}, 32'({en_erase, en_write, en_read}), 32'(g));
    chk({tag, "_op"}, 32'(op_active), 32'(op));
    if (g[0]) begin req_read  = 1'b0; read_busy  = 1'b1; end
    if (g[1]) begin req_write = 1'b0; write_busy = 1'b1; end
    if (g[2]) begin req_erase = 1'b0; erase_busy = 1'b1; end
    tick();
    chk_state({tag, "_wait"}, 3'd3);
    chk({tag, "_gnt_off"}, 32'(gnt), 32'd0);
    tick();
    chk_state({tag, "_run"}, 3'd4);
    tick();
    tick();
    read_busy  = 1'b0;
    write_busy = 1'b0;
    erase_busy = 1'b0;
    tick();
    chk_state({tag, "_done"}, 3'd5);
    tick();
    chk_state({tag, "_idle"}, 3'd0);
    chk({tag, "_op_clr"}, 32'(op_active), 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    req_read = 1'b0; req_write = 1'b0; req_erase = 1'b0;
    read_busy = 1'b0; write_busy = 1'b0; erase_busy = 1'b0;
    tick();
    tick();
    chk_state("rst_state", 3'd0);
    chk("rst_outs", 32'({en_erase, en_write, en_read, gnt, op_active, timeout_err}), 32'd0);
    rst = 1'b1;
    tick();
    chk_state("idle_hold", 3'd0);

    // Single read with explicit 2-cycle latency and 10 busy cycles.
    req_read = 1'b1;
    tick();
    chk_state("rd_arb", 3'd1);
    chk("rd_no_early_en", 32'(en_read), 32'd0);
    tick();
    chk("rd_en", 32'(en_read), 32'd1);
    chk("rd_gnt", 32'(gnt), 32'b001);
    chk("rd_op", 32'(op_active), 32'd1);
    req_read  = 1'b0;
    read_busy = 1'b1;
    tick();
    chk_state("rd_wait", 3'd3);
    chk("rd_en_pulse", 32'(en_read), 32'd0);
    for (int i = 0; i < 10; i++) tick();
    chk_state("rd_run10", 3'd4);
    read_busy = 1'b0;
    tick();
    chk_state("rd_done", 3'd5);
    chk("rd_op_done", 32'(op_active), 32'd1);
    tick();
    chk_state("rd_idle", 3'd0);
    chk("rd_op_clr", 32'(op_active), 32'd0);

    // Priority: erase, then write, then read.
    req_read = 1'b1; req_write = 1'b1; req_erase = 1'b1;
    grant_and_run("pri_erase", 3'b100, 2'd3);
    grant_and_run("pri_write", 3'b010, 2'd2);
    grant_and_run("pri_read",  3'b001, 2'd1);

    // Starvation: four write wins, then read wins on the fifth arbitration.
    req_read = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_write = 1'b1;
      grant_and_run("stv_write", 3'b010, 2'd2);
    end
    req_write = 1'b1;
    grant_and_run("stv_read5", 3'b001, 2'd1);
    // Counter cleared: write beats read again, then read follows.
    req_read = 1'b1;
    grant_and_run("stv_clr_write", 3'b010, 2'd2);
    grant_and_run("stv_clr_read", 3'b001, 2'd1);

    // Request dropped before arbitration is never granted.
    req_write = 1'b1;
    tick();
    chk_state("drop_arb", 3'd1);
    req_write = 1'b0;
    tick();
    chk_state("drop_idle", 3'd0);
    chk("drop_gnt", 32'(gnt), 32'd0);

    // No start: write engine never goes busy; other busies must be ignored.
    req_write = 1'b1;
    tick();
    tick();
    chk("ns_gnt", 32'(gnt), 32'b010);
    req_write  = 1'b0;
    read_busy  = 1'b1;
    erase_busy = 1'b1;
    tick();
    chk_state("ns_wait0", 3'd3);
    tick();
    tick();
    tick();
    chk_state("ns_wait3", 3'd3);
    chk("ns_err_clear", 32'(timeout_err), 32'd0);
    tick();
    chk_state("ns_err", 3'd6);
    tick();
    chk_state("ns_idle", 3'd0);
    chk("ns_flag", 32'(timeout_err), 32'd1);
    chk("ns_op_clr", 32'(op_active), 32'd0);
    read_busy  = 1'b0;
    erase_busy = 1'b0;
    tick();
    tick();
    chk("ns_sticky", 32'(timeout_err), 32'd1);

    // Hang: erase busy stuck high.
    req_erase = 1'b1;
    tick();
    tick();
    chk("hang_gnt", 32'(gnt), 32'b100);
    req_erase  = 1'b0;
    erase_busy = 1'b1;
    tick();
    chk_state("hang_wait", 3'd3);
    tick();
    chk_state("hang_run0", 3'd4);
    for (int i = 0; i < 15; i++) tick();
    chk_state("hang_run15", 3'd4);
    tick();
`ifdef FLASH_OP_TIMEOUT_EN
    chk_state("hang_err", 3'd6);
    tick();
    chk_state("hang_idle", 3'd0);
    erase_busy = 1'b0;
`else
    chk_state("hang_stay", 3'd4);
    for (int i = 0; i < 20; i++) tick();
    chk_state("hang_stay_long", 3'd4);
    erase_busy = 1'b0;
    tick();
    chk_state("hang_done", 3'd5);
    tick();
    chk_state("hang_idle", 3'd0);
`endif
    chk("hang_flag", 32'(timeout_err), 32'd1);

    // Reset during a read in RUN.
    req_read = 1'b1;
    tick();
    tick();
    chk("rr_en", 32'(en_read), 32'd1);
    req_read  = 1'b0;
    read_busy = 1'b1;
    tick();
    tick();
    chk_state("rr_run", 3'd4);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk_state("rr_idle", 3'd0);
    chk("rr_outs", 32'({en_erase, en_write, en_read, gnt, op_active, timeout_err}), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rr_no_reissue", 32'({sched_state, en_erase, en_write, en_read, gnt}), 32'd0);
    end
    read_busy = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
